// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: writeback select encodings, memory-stage FSM states
// and the default datapath width.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_RSP
    } mem_state_t;

endpackage

// File: rtl/mem_stage.sv
// Memory pipeline stage: word loads/stores over a valid/ready bus with a separate
// response strobe, stalls upstream while an access is outstanding, feeds writeback.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEFAULT,
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_write_data,
    input  logic [XLEN-1:0] in_pc_plus_4,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_result_src,
    input  logic            in_mem_write,
    input  logic            in_mem_read,
    input  logic            in_reg_write,
    output logic [XLEN-1:0] fwd_alu_data,
    output logic            mem_stall,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_read_data,
    output logic [XLEN-1:0] wb_pc_plus_4,
    output logic [4:0]      wb_rd,
    output logic [1:0]      wb_result_src,
    output logic            wb_reg_write,
    output logic            mem_err
);

    localparam int unsigned CW = $clog2(RSP_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RSP_TIMEOUT - 1);

    mem_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          access, misaligned, is_store;
    logic          complete, read_done, err_d;

    assign access       = in_mem_read | in_mem_write;
    assign misaligned   = access & (in_alu_result[1:0] != 2'b00);
    assign is_store     = in_mem_write & ~in_mem_read;
    assign fwd_alu_data = in_alu_result;
    assign dmem_addr    = in_alu_result;
    assign dmem_wdata   = in_write_data;
    assign dmem_we      = is_store;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dmem_req_valid = 1'b0;
        mem_stall      = 1'b0;
        complete       = 1'b0;
        read_done      = 1'b0;
        err_d          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!access) begin
                    complete = 1'b1;
                end else if (misaligned) begin
                    err_d = 1'b1;
                end else begin
                    dmem_req_valid = 1'b1;
                    if (dmem_req_ready && is_store) begin
                        complete = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                        if (dmem_req_ready) begin
                            state_d = WAIT_RSP;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            WAIT_RSP: begin
                // A response arriving on the timeout cycle still completes the load.
                if (dmem_rsp_valid) begin
                    read_done = 1'b1;
                    complete  = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    mem_stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wb_alu_result <= '0;
            wb_read_data  <= '0;
            wb_pc_plus_4  <= '0;
            wb_rd         <= '0;
            wb_result_src <= '0;
            wb_reg_write  <= 1'b0;
            mem_err       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_err <= err_d;
            if (complete) begin
                wb_alu_result <= in_alu_result;
                wb_pc_plus_4  <= in_pc_plus_4;
                wb_rd         <= in_rd;
                wb_result_src <= in_result_src;
                wb_reg_write  <= in_reg_write;
            end else begin
                // Bubble: stall, misaligned or aborted access.
                wb_rd        <= '0;
                wb_reg_write <= 1'b0;
            end
            if (read_done) begin
                wb_read_data <= dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a cycle-level behavioural
// model of load/store completion, stalls, timeouts and writeback bubbles.
module tb_mem_stage;
    import riscv_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_alu_result, in_write_data, in_pc_plus_4;
    logic [4:0]  in_rd;
    logic [1:0]  in_result_src;
    logic        in_mem_write, in_mem_read, in_reg_write;
    logic [31:0] fwd_alu_data;
    logic        mem_stall, dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic [31:0] wb_alu_result, wb_read_data, wb_pc_plus_4;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_result_src;
    logic        wb_reg_write, mem_err;

    mem_stage #(.XLEN(32), .RSP_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_alu_result(in_alu_result), .in_write_data(in_write_data),
        .in_pc_plus_4(in_pc_plus_4), .in_rd(in_rd), .in_result_src(in_result_src),
        .in_mem_write(in_mem_write), .in_mem_read(in_mem_read), .in_reg_write(in_reg_write),
        .fwd_alu_data(fwd_alu_data), .mem_stall(mem_stall),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
        .wb_pc_plus_4(wb_pc_plus_4), .wb_rd(wb_rd), .wb_result_src(wb_result_src),
        .wb_reg_write(wb_reg_write), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: whether a load is outstanding and how many wait cycles it has used.
    bit          m_wait;
    int          m_waited;
    bit          last_stall;
    logic [31:0] e_alu, e_rdata, e_pc;
    logic [4:0]  e_rd;
    logic [1:0]  e_src;
    logic        e_rw, e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_cycle(input bit rst);
        bit acc, mis, st, done, err, exp_req, exp_stall;
        @(negedge clk);
        acc = in_mem_read | in_mem_write;
        mis = acc && (in_alu_result % 4 != 0);
        st  = in_mem_write && !in_mem_read;
        done = 0; err = 0; exp_req = 0; exp_stall = 0;
        if (!m_wait) begin
            exp_req   = acc && !mis;
            exp_stall = acc && !mis && !(dmem_req_ready && st);
            done      = !acc || (acc && !mis && dmem_req_ready && st);
            err       = mis;
        end else begin
            done      = dmem_rsp_valid;
            err       = !dmem_rsp_valid && (m_waited == TO - 1);
            exp_stall = !dmem_rsp_valid && !err;
        end
        if (!rst) begin
            chk("fwd", fwd_alu_data, in_alu_result);
            chk("addr", dmem_addr, in_alu_result);
            chk("wdata", dmem_wdata, in_write_data);
            chk("we", dmem_we, st);
            chk("req_valid", dmem_req_valid, exp_req);
            chk("stall", mem_stall, exp_stall);
        end
        if (rst) begin
            m_wait = 0; e_alu = 0; e_rdata = 0; e_pc = 0; e_rd = 0; e_src = 0;
            e_rw = 0; e_err = 0; exp_stall = 0;
        end else begin
            if (done) begin
                e_alu = in_alu_result; e_pc = in_pc_plus_4; e_rd = in_rd;
                e_src = in_result_src; e_rw = in_reg_write;
            end else begin
                e_rd = 0; e_rw = 0;
            end
            e_err = err;
            if (m_wait) begin
                if (dmem_rsp_valid) e_rdata = dmem_rdata;
                if (done || err) m_wait = 0;
                else m_waited++;
            end else if (acc && !mis && !st && dmem_req_ready) begin
                m_wait = 1; m_waited = 0;
            end
        end
        last_stall = exp_stall;
        @(posedge clk);
        #1;
        chk("wb_alu", wb_alu_result, e_alu);
        chk("wb_rdata", wb_read_data, e_rdata);
        chk("wb_pc4", wb_pc_plus_4, e_pc);
        chk("wb_rd", wb_rd, e_rd);
        chk("wb_src", wb_result_src, e_src);
        chk("wb_rw", wb_reg_write, e_rw);
        chk("mem_err", mem_err, e_err);
    endtask

    task automatic set_instr(input int kind);
        logic [31:0] r;
        r = $urandom();
        in_alu_result = r & 32'hFFFF_FFFC;
        in_write_data = $urandom();
        in_pc_plus_4  = $urandom();
        in_rd         = 5'($urandom_range(0, 31));
        in_mem_read   = (kind == 2) || (kind == 3);
        in_mem_write  = (kind == 1) || (kind == 3);
        in_result_src = ($urandom_range(0, 1) == 0) ? RES_ALU : RES_PC4;
        in_reg_write  = 1'($urandom_range(0, 1));
        if (kind == 4) begin
            in_mem_read   = 1'($urandom_range(0, 1));
            in_mem_write  = !in_mem_read;
            in_alu_result = in_alu_result | 32'($urandom_range(1, 3));
        end
        if (in_mem_read) in_result_src = RES_MEM;
        if (kind == 1) in_reg_write = 1'b0;
    endtask

    task automatic rand_bus();
        dmem_req_ready = ($urandom_range(0, 2) != 0);
        dmem_rsp_valid = ($urandom_range(0, 3) == 0);
        dmem_rdata     = $urandom();
    endtask

    initial begin
        m_wait = 0; m_waited = 0; last_stall = 0;
        reset = 1'b1;
        in_alu_result = 0; in_write_data = 0; in_pc_plus_4 = 0; in_rd = 0;
        in_result_src = 0; in_mem_write = 0; in_mem_read = 0; in_reg_write = 0;
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
        do_cycle(1);
        do_cycle(1);
        reset = 1'b0;

        // Directed load: accepted at once, response three cycles after acceptance.
        set_instr(2);
        in_alu_result = 32'h200; in_reg_write = 1'b1;
        dmem_req_ready = 1'b1;
        do_cycle(0);
        dmem_req_ready = 1'b0;
        do_cycle(0);
        do_cycle(0);
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        do_cycle(0);
        dmem_rsp_valid = 1'b0;
        chk("dir_load_rdata", wb_read_data, 32'hCAFE_F00D);
        chk("dir_load_rw", wb_reg_write, 1'b1);

        // Reset while a load is outstanding.
        set_instr(2);
        dmem_req_ready = 1'b1;
        do_cycle(0);
        dmem_req_ready = 1'b0;
        do_cycle(0);
        reset = 1'b1;
        do_cycle(1);
        reset = 1'b0;
        dmem_rsp_valid = 1'b1;
        set_instr(0);
        do_cycle(0);
        dmem_rsp_valid = 1'b0;

        for (int i = 0; i < 400; i++) begin
            set_instr($urandom_range(0, 4));
            for (int c = 0; c < 40; c++) begin
                rand_bus();
                do_cycle(0);
                if (!last_stall) break;
            end
            if (last_stall) chk("stall_bound", mem_stall, 1'b0);
            // Occasional reset between instructions.
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                do_cycle(1);
                reset = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
